// File: rtl/capture_ctrl.sv
`default_nettype none
// ============================================================================
// capture_ctrl : circular-buffer write controller with pre/post-trigger tracking
// Revision     : 1.0
// ============================================================================
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wrt_smpl,
  input  logic            run,
  input  logic            capture_done,
  input  logic            triggered,
  input  logic [LOG2-1:0] trig_pos,
  output logic            we,
  output logic [LOG2-1:0] waddr,
  output logic            set_capture_done,
  output logic            armed,
  output logic            capturing
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_WAIT_RD = 2'd2;

  localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);
  localparam logic [LOG2:0]   DEPTH     = (LOG2 + 1)'(ENTRIES);

  logic [1:0]      state_q, state_d;
  logic [LOG2-1:0] waddr_q, waddr_d;
  logic [LOG2-1:0] trig_cnt_q, trig_cnt_d;
  logic [LOG2:0]   smpl_cnt_q, smpl_cnt_d;
  logic            trig_seen_q, trig_seen_d;
  logic            armed_q, armed_d;
  logic            set_done_q, set_done_d;
  logic            cd_seen_q, cd_seen_d;
  logic [1:0]      wait_cnt_q, wait_cnt_d;

  logic [LOG2-1:0] tp;
  logic            in_capture;
  logic            done_cond;
  logic            wr_now;

  always_comb begin
    tp         = ({1'b0, trig_pos} >= DEPTH) ? LAST_ADDR : trig_pos;
    in_capture = (state_q == ST_CAPTURE);
    done_cond  = in_capture && trig_seen_q && (trig_cnt_q == tp);
    // a write coinciding with completion is dropped so waddr lands on the oldest sample
    wr_now     = in_capture && wrt_smpl && !done_cond;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      waddr_q     <= '0;
      trig_cnt_q  <= '0;
      smpl_cnt_q  <= '0;
      trig_seen_q <= 1'b0;
      armed_q     <= 1'b0;
      set_done_q  <= 1'b0;
      cd_seen_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      trig_cnt_q  <= trig_cnt_d;
      smpl_cnt_q  <= smpl_cnt_d;
      trig_seen_q <= trig_seen_d;
      armed_q     <= armed_d;
      set_done_q  <= set_done_d;
      cd_seen_q   <= cd_seen_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    trig_cnt_d  = trig_cnt_q;
    smpl_cnt_d  = smpl_cnt_q;
    trig_seen_d = trig_seen_q;
    armed_d     = armed_q;
    set_done_d  = done_cond;
    cd_seen_d   = cd_seen_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (run && !capture_done) begin
          state_d     = ST_CAPTURE;
          waddr_d     = '0;
          smpl_cnt_d  = '0;
          trig_cnt_d  = '0;
          trig_seen_d = 1'b0;
          armed_d     = 1'b0;
        end
      end

      ST_CAPTURE: begin
        if (wr_now) begin
          waddr_d = (waddr_q == LAST_ADDR) ? '0 : waddr_q + 1'b1;
          if (smpl_cnt_q != DEPTH) begin
            smpl_cnt_d = smpl_cnt_q + 1'b1;
          end
          if (trig_seen_q) begin
            trig_cnt_d = trig_cnt_q + 1'b1;
          end
        end
        if ((smpl_cnt_q + {1'b0, tp}) >= DEPTH) begin
          armed_d = 1'b1;
        end
        if (triggered && armed_q) begin
          trig_seen_d = 1'b1;
        end
        if (done_cond) begin
          state_d    = ST_WAIT_RD;
          armed_d    = 1'b0;
          cd_seen_d  = 1'b0;
          wait_cnt_d = '0;
        end else if (!run) begin
          state_d = ST_IDLE;
          armed_d = 1'b0;
        end
      end

      ST_WAIT_RD: begin
        if (capture_done) begin
          cd_seen_d = 1'b1;
        end
        if (wait_cnt_q != 2'd3) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        // leave after the host readout handshake, or if the status bit never rose
        if (cd_seen_q && !capture_done) begin
          state_d = ST_IDLE;
        end else if (!cd_seen_q && !capture_done && (wait_cnt_q == 2'd2)) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    we               = wr_now;
    capturing        = in_capture;
    waddr            = waddr_q;
    armed            = armed_q;
    set_capture_done = set_done_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_capture_ctrl.sv
`default_nettype none
// ============================================================================
// tb_capture_ctrl : scoreboard bench for capture_ctrl (write addresses, done pulse)
// Revision        : 1.0
// ============================================================================
module tb_capture_ctrl;

  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  logic            clk;
  logic            rst_n;
  logic            wrt_smpl;
  logic            run;
  logic            capture_done;
  logic            triggered;
  logic [LOG2-1:0] trig_pos;
  logic            we;
  logic [LOG2-1:0] waddr;
  logic            set_capture_done;
  logic            armed;
  logic            capturing;

  capture_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wrt_smpl         (wrt_smpl),
    .run              (run),
    .capture_done     (capture_done),
    .triggered        (triggered),
    .trig_pos         (trig_pos),
    .we               (we),
    .waddr            (waddr),
    .set_capture_done (set_capture_done),
    .armed            (armed),
    .capturing        (capturing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_we_q[$];
  int exp_done_q[$];
  int exp_addr;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: every write and every done pulse must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (we) begin
        checks++;
        if (exp_we_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_we actual_waddr=%0d expected=no_write", waddr);
        end else begin
          int e;
          e = exp_we_q.pop_front();
          if (int'(waddr) != e) begin
            failures++;
            $display("FAIL write_addr actual=%0d expected=%0d", waddr, e);
          end
        end
      end
      if (set_capture_done) begin
        checks++;
        if (exp_done_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done actual_waddr=%0d expected=no_pulse", waddr);
        end else begin
          int e;
          e = exp_done_q.pop_front();
          if (int'(waddr) != e) begin
            failures++;
            $display("FAIL done_addr actual=%0d expected=%0d", waddr, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_write();
    exp_we_q.push_back(exp_addr);
    exp_addr = (exp_addr == ENTRIES - 1) ? 0 : exp_addr + 1;
  endtask

  // One decimated sample every four clocks
  task automatic write_one(input logic trig);
    wrt_smpl  = 1'b1;
    triggered = trig;
    push_write();
    tick();
    wrt_smpl  = 1'b0;
    triggered = 1'b0;
    repeat (3) tick();
  endtask

  task automatic start_capture(input int tpv);
    trig_pos = LOG2'(tpv);
    exp_addr = 0;
    run      = 1'b1;
    tick();
    check("capturing_start", int'(capturing), 1);
  endtask

  initial begin
    int armed_cyc;
    int done_cyc;

    rst_n        = 1'b0;
    wrt_smpl     = 1'b0;
    run          = 1'b0;
    capture_done = 1'b0;
    triggered    = 1'b0;
    trig_pos     = '0;
    exp_addr     = 0;
    #12;
    check("rst_we", int'(we), 0);
    check("rst_waddr", int'(waddr), 0);
    check("rst_done", int'(set_capture_done), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_capturing", int'(capturing), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Pre-trigger fill with trig_pos=100: arming after the 284th write
    start_capture(100);
    repeat (283) write_one(1'b0);
    check("armed_before_284", int'(armed), 0);
    wrt_smpl = 1'b1;
    push_write();
    tick();
    wrt_smpl = 1'b0;
    check("armed_at_284_edge", int'(armed), 0);
    tick();
    check("armed_after_284", int'(armed), 1);
    check("waddr_at_arm", int'(waddr), 284);
    repeat (2) tick();

    // Trigger on write 500, then exactly 100 post-trigger writes (wraps 383->0)
    repeat (215) write_one(1'b0);
    write_one(1'b1);
    repeat (99) write_one(1'b0);
    exp_done_q.push_back(216);
    wrt_smpl = 1'b1;
    push_write();
    tick();
    wrt_smpl = 1'b0;
    run      = 1'b0;          // run drop coincides with completion
    check("we_in_done_cycle", int'(we), 0);
    check("done_not_early", int'(set_capture_done), 0);
    tick();
    check("done_pulse", int'(set_capture_done), 1);
    check("final_waddr", int'(waddr), 216);
    check("armed_wait_rd", int'(armed), 0);
    check("capturing_wait_rd", int'(capturing), 0);
    tick();
    check("done_one_cycle", int'(set_capture_done), 0);
    capture_done = 1'b1;
    repeat (2) tick();
    capture_done = 1'b0;
    repeat (3) tick();

    // trig_pos=0 with trigger held and samples every clock
    trig_pos = '0;
    exp_addr = 0;
    repeat (386) push_write();
    exp_done_q.push_back(2);
    run       = 1'b1;
    wrt_smpl  = 1'b1;
    triggered = 1'b1;
    armed_cyc = -1;
    done_cyc  = -1;
    for (int c = 0; c < 600 && done_cyc < 0; c++) begin
      tick();
      if (armed && armed_cyc < 0) armed_cyc = c;
      if (set_capture_done) begin
        done_cyc  = c;
        run       = 1'b0;
        wrt_smpl  = 1'b0;
        triggered = 1'b0;
      end
    end
    run       = 1'b0;
    wrt_smpl  = 1'b0;
    triggered = 1'b0;
    check("tp0_done_seen", int'(done_cyc >= 0), 1);
    check("tp0_done_latency", done_cyc - armed_cyc, 2);
    repeat (4) tick();

    // trig_pos=511 clamps to 383: armed right after the first write
    start_capture(511);
    wrt_smpl = 1'b1;
    push_write();
    tick();
    wrt_smpl = 1'b0;
    check("clamp_armed_edge", int'(armed), 0);
    tick();
    check("clamp_armed", int'(armed), 1);
    run = 1'b0;
    tick();
    check("clamp_abort_armed", int'(armed), 0);
    check("clamp_abort_capturing", int'(capturing), 0);
    repeat (2) tick();

    // Early trigger ignored, then abort
    start_capture(100);
    repeat (10) write_one(1'b0);
    triggered = 1'b1;
    tick();
    triggered = 1'b0;
    repeat (400) write_one(1'b0);
    check("early_trig_armed", int'(armed), 1);
    check("early_trig_capturing", int'(capturing), 1);
    run = 1'b0;
    tick();
    check("abort_capturing", int'(capturing), 0);
    check("abort_armed", int'(armed), 0);
    repeat (2) tick();

    // Asynchronous reset mid-capture at waddr=150
    start_capture(383);
    repeat (150) write_one(1'b0);
    check("pre_reset_waddr", int'(waddr), 150);
    check("pre_reset_armed", int'(armed), 1);
    wrt_smpl = 1'b1;
    #1;
    check("pre_reset_we", int'(we), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_we", int'(we), 0);
    check("async_waddr", int'(waddr), 0);
    check("async_armed", int'(armed), 0);
    check("async_capturing", int'(capturing), 0);
    check("async_done", int'(set_capture_done), 0);
    wrt_smpl     = 1'b0;
    capture_done = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    check("blocked_by_capture_done", int'(capturing), 0);
    capture_done = 1'b0;
    exp_addr     = 0;
    tick();
    check("start_after_release", int'(capturing), 1);
    run = 1'b0;
    repeat (3) tick();

    check("we_queue_empty", exp_we_q.size(), 0);
    check("done_queue_empty", exp_done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
